// File: rtl/result_drain_buffer_pkg.sv
// Shared definitions for the matmul result drain path: output word geometry
// and the drain FSM state type.
package out0_pkg;

    // Width of one matmul result word.
    localparam int OUT0_WIDTH = 16;

    // Number of buffered entries (power of two); one entry holds one word per
    // buffer instance.
    localparam int OUT0_DEPTH = 8;

    // Drain FSM: IDLE waits for a stored entry, SEND serializes one entry
    // word-by-word onto the downstream port.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_e;

endpackage : out0_pkg

// File: rtl/result_drain_buffer_if.sv
// Bundles the matmul result capture port and the serialized downstream port.
// The slave modport is the buffer's view; the master modport is the view of
// whatever feeds results in and drains beats out.
interface result_drain_buffer_if
    import out0_pkg::*;
#(
    parameter int NUMBER_OF_BUFFER_INSTANCES = 4,
    parameter int OUT_WIDTH                  = OUT0_WIDTH
);

    localparam int IDX_W = (NUMBER_OF_BUFFER_INSTANCES > 1) ?
                           $clog2(NUMBER_OF_BUFFER_INSTANCES) : 1;

    // Capture side: one result beat carries a word from every instance.
    logic                 in_valid;
    logic [OUT_WIDTH-1:0] in_data [NUMBER_OF_BUFFER_INSTANCES];

    // Drain side: one word per handshake, tagged with its instance index.
    logic                 m_valid;
    logic                 m_ready;
    logic [OUT_WIDTH-1:0] m_data;
    logic [IDX_W-1:0]     m_inst_idx;
    logic                 m_last;

    modport master (
        output in_valid,
        output in_data,
        output m_ready,
        input  m_valid,
        input  m_data,
        input  m_inst_idx,
        input  m_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  m_ready,
        output m_valid,
        output m_data,
        output m_inst_idx,
        output m_last
    );

endinterface : result_drain_buffer_if

// File: rtl/result_drain_buffer_fifo.sv
// Entry-wide circular buffer for matmul results: one write port and one
// asynchronous read port, both a full entry (all instance words) wide.
module result_fifo
    import out0_pkg::*;
#(
    parameter int NUMBER_OF_BUFFER_INSTANCES = 4,
    parameter int OUT_WIDTH                  = OUT0_WIDTH,
    parameter int DEPTH                      = OUT0_DEPTH
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  wr_en_i,
    input  logic [NUMBER_OF_BUFFER_INSTANCES-1:0][OUT_WIDTH-1:0] wr_data_i,
    input  logic                                                  pop_i,
    output logic [NUMBER_OF_BUFFER_INSTANCES-1:0][OUT_WIDTH-1:0] rd_data_o,
    output logic [$clog2(DEPTH):0]                                count_o,
    output logic                                                  full_o,
    output logic                                                  empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef logic [NUMBER_OF_BUFFER_INSTANCES-1:0][OUT_WIDTH-1:0] entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_fire;
    logic             pop_fire;

    // Fullness comes from the registered count only, so a write that lands
    // in the same cycle as a pop from a full buffer is still refused.
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign wr_fire  = wr_en_i && !full_o;
    assign pop_fire = pop_i && !empty_o;

    // Asynchronous read of the entry currently being drained.
    assign rd_data_o = mem_q[rd_ptr_q];

    // Next-state pointers and occupancy; pointers wrap to zero in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_fire) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({wr_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule : result_fifo

// File: rtl/result_drain_buffer.sv
// Captures whole matmul result beats (one word per buffer instance) without
// backpressuring the source, and drains them one word per handshake with the
// instance index and an end-of-entry marker.
module result_drain_buffer
    import out0_pkg::*;
#(
    parameter int NUMBER_OF_BUFFER_INSTANCES = 4,
    parameter int OUT_WIDTH                  = OUT0_WIDTH,
    parameter int DEPTH                      = OUT0_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    result_drain_buffer_if.slave    bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow
);

    localparam int N     = NUMBER_OF_BUFFER_INSTANCES;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef logic [N-1:0][OUT_WIDTH-1:0] entry_t;

    drain_state_e     state_q;
    logic [IDX_W-1:0] beat_idx_q;
    logic             m_valid_q;
    logic             m_last_q;
    logic             overflow_q;

    entry_t wr_entry;
    entry_t rd_entry;
    logic   wr_accept;
    logic   pop;
    logic   more_entries;

    // Pack the instance-indexed capture words into one storage entry.
    always_comb begin
        wr_entry = '0;
        for (int unsigned i = 0; i < N; i++) begin
            wr_entry[i] = bus.in_data[i];
        end
    end

    assign wr_accept = bus.in_valid && !full;

    // The final word of an entry is being accepted downstream.
    assign pop = (state_q == SEND) && bus.m_ready && (beat_idx_q == LAST_IDX);

    // An entry remains after this pop if more than one was stored, or a new
    // one lands in the same cycle; either way SEND continues without a bubble.
    assign more_entries = (count > CNT_W'(1)) || wr_accept;

    result_fifo #(
        .NUMBER_OF_BUFFER_INSTANCES (N),
        .OUT_WIDTH                  (OUT_WIDTH),
        .DEPTH                      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bus.in_valid),
        .wr_data_i (wr_entry),
        .pop_i     (pop),
        .rd_data_o (rd_entry),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    // Drain FSM: walks beat_idx across the head entry, one word per handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_idx_q <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (count != '0) begin
                        state_q    <= SEND;
                        m_valid_q  <= 1'b1;
                        beat_idx_q <= '0;
                        m_last_q   <= (N == 1);
                    end
                end
                SEND: begin
                    if (bus.m_ready) begin
                        if (beat_idx_q == LAST_IDX) begin
                            beat_idx_q <= '0;
                            if (more_entries) begin
                                m_last_q <= (N == 1);
                            end else begin
                                state_q   <= IDLE;
                                m_valid_q <= 1'b0;
                                m_last_q  <= 1'b0;
                            end
                        end else begin
                            beat_idx_q <= beat_idx_q + 1'b1;
                            m_last_q   <= ((beat_idx_q + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky record that a result beat arrived while the buffer was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (bus.in_valid && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.m_valid    = m_valid_q;
    assign bus.m_last     = m_last_q;
    assign bus.m_inst_idx = beat_idx_q;
    assign bus.m_data     = rd_entry[beat_idx_q];
    assign overflow       = overflow_q;

endmodule : result_drain_buffer

// File: tb/tb_result_drain_buffer.sv
// Self-checking bench for result_drain_buffer. A reference model tracks
// accepted entries as a queue of expected beats and the stored entry count;
// observed handshakes are collected and compared against it per scenario.
module tb_result_drain_buffer;
    import out0_pkg::*;

    localparam int N  = 4;
    localparam int W  = OUT0_WIDTH;
    localparam int D  = OUT0_DEPTH;
    localparam int CW = $clog2(D) + 1;

    typedef struct {
        logic [W-1:0] data;
        int           idx;
        bit           last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    beat_t exp_q[$];
    beat_t act_q[$];
    int    mcount = 0;
    int    mbeat  = 0;
    bit    mov    = 1'b0;

    result_drain_buffer_if #(.NUMBER_OF_BUFFER_INSTANCES(N), .OUT_WIDTH(W)) bus ();

    result_drain_buffer #(
        .NUMBER_OF_BUFFER_INSTANCES (N),
        .OUT_WIDTH                  (W),
        .DEPTH                      (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_in(input bit v);
        bus.in_valid = v;
        for (int i = 0; i < N; i++) bus.in_data[i] = v ? W'($urandom) : 'x;
    endtask

    // One clock: update the model from pre-edge inputs/outputs, then advance.
    task automatic tick();
        bit    hs;
        bit    acc;
        bit    popped;
        beat_t b;
        hs     = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b1);
        acc    = 1'b0;
        popped = 1'b0;
        if (rst) begin
            mcount = 0;
            mbeat  = 0;
            mov    = 1'b0;
            exp_q.delete();
            act_q.delete();
        end else begin
            if (hs) begin
                b.data = bus.m_data;
                b.idx  = int'(bus.m_inst_idx);
                b.last = bus.m_last;
                act_q.push_back(b);
                if (mbeat == N - 1) begin
                    mbeat  = 0;
                    popped = 1'b1;
                end else begin
                    mbeat++;
                end
            end
            if (bus.in_valid === 1'b1) begin
                if (mcount < D) begin
                    acc = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        b.data = bus.in_data[i];
                        b.idx  = i;
                        b.last = (i == N - 1);
                        exp_q.push_back(b);
                    end
                end else begin
                    mov = 1'b1;
                end
            end
            mcount = mcount + int'(acc) - int'(popped);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, output bit timed_out);
        int n;
        n = 0;
        while (mcount != 0 && n < budget) begin
            tick();
            n++;
        end
        timed_out = (mcount != 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_in(1'b0);
        bus.m_ready = 1'b0;
        tick();
        tick();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b exp 0", bus.m_valid); end
        checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b exp 0", bus.m_last); end
        checks++; if (bus.m_inst_idx !== '0) begin errors++; $display("FAIL reset_m_inst_idx: got %0d exp 0", bus.m_inst_idx); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", full); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit to;
        exp_q.delete(); act_q.delete();
        bus.m_ready = 1'b1;
        drive_in(1'b1);
        tick();
        drive_in(1'b0);
        checks++; if (count !== CW'(1)) begin errors++; $display("FAIL basic_count_after_write: got %0d exp 1", count); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got m_valid=%b exp 0", bus.m_valid); end
        tick();
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid: got m_valid=%b exp 1", bus.m_valid); end
        drain(40, to);
        checks++; if (to) begin errors++; $display("FAIL basic_drain_timeout: got count=%0d exp 0", mcount); end
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_beat_count: got %0d exp %0d", act_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            checks++;
            if (act_q[k].data !== exp_q[k].data || act_q[k].idx != exp_q[k].idx || act_q[k].last != exp_q[k].last) begin
                errors++;
                $display("FAIL basic_beat%0d: got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                         k, act_q[k].data, act_q[k].idx, act_q[k].last, exp_q[k].data, exp_q[k].idx, exp_q[k].last);
            end
        end
        checks++; if (empty !== 1'b1 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_after: got empty=%b m_valid=%b exp 1/0", empty, bus.m_valid); end
    endtask

    task automatic test_backpressure();
        bit           pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] d0;
        logic [$clog2(N)-1:0] i0;
        logic         l0;
        exp_q.delete(); act_q.delete();
        bus.m_ready = 1'b0;
        drive_in(1'b1);
        tick();
        drive_in(1'b0);
        for (int c = 0; c < 60 && mcount != 0; c++) begin
            bus.m_ready = pat[c % 4];
            if (bus.m_valid === 1'b1 && !bus.m_ready) begin
                d0 = bus.m_data; i0 = bus.m_inst_idx; l0 = bus.m_last;
                tick();
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== d0 || bus.m_inst_idx !== i0 || bus.m_last !== l0) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b data=%h idx=%0d last=%b exp v=1 data=%h idx=%0d last=%b",
                             bus.m_valid, bus.m_data, bus.m_inst_idx, bus.m_last, d0, i0, l0);
                end
            end else begin
                tick();
            end
        end
        checks++; if (mcount != 0) begin errors++; $display("FAIL bp_drain_timeout: got count=%0d exp 0", mcount); end
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_beat_count: got %0d exp %0d", act_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            checks++;
            if (act_q[k].data !== exp_q[k].data || act_q[k].idx != exp_q[k].idx || act_q[k].last != exp_q[k].last) begin
                errors++;
                $display("FAIL bp_beat%0d: got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                         k, act_q[k].data, act_q[k].idx, act_q[k].last, exp_q[k].data, exp_q[k].idx, exp_q[k].last);
            end
        end
    endtask

    task automatic test_overflow();
        bit to;
        exp_q.delete(); act_q.delete();
        bus.m_ready = 1'b0;
        for (int k = 0; k < D + 1; k++) begin
            drive_in(1'b1);
            tick();
            if (k == D - 1) begin
                checks++; if (full !== 1'b1 || count !== CW'(D)) begin errors++; $display("FAIL ovf_full_at_depth: got full=%b count=%0d exp 1/%0d", full, count, D); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b exp 0", overflow); end
            end
        end
        drive_in(1'b0);
        checks++; if (overflow !== mov) begin errors++; $display("FAIL ovf_flag: got %b exp %b", overflow, mov); end
        checks++; if (count !== CW'(mcount)) begin errors++; $display("FAIL ovf_count: got %0d exp %0d", count, mcount); end
        bus.m_ready = 1'b1;
        drain(D * N + 20, to);
        checks++; if (to) begin errors++; $display("FAIL ovf_drain_timeout: got count=%0d exp 0", mcount); end
        checks++; if (act_q.size() != D * N) begin errors++; $display("FAIL ovf_beat_count: got %0d exp %0d", act_q.size(), D * N); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            checks++;
            if (act_q[k].data !== exp_q[k].data || act_q[k].idx != exp_q[k].idx || act_q[k].last != exp_q[k].last) begin
                errors++;
                $display("FAIL ovf_beat%0d: got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                         k, act_q[k].data, act_q[k].idx, act_q[k].last, exp_q[k].data, exp_q[k].idx, exp_q[k].last);
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
    endtask

    task automatic test_simultaneous();
        bit to;
        int n;
        rst = 1'b1; tick(); rst = 1'b0;
        // Full buffer: write coincident with final-beat pop is dropped.
        bus.m_ready = 1'b0;
        for (int k = 0; k < D; k++) begin drive_in(1'b1); tick(); end
        drive_in(1'b0);
        bus.m_ready = 1'b1;
        n = 0;
        while (!(bus.m_valid === 1'b1 && mbeat == N - 1) && n < 50) begin tick(); n++; end
        checks++; if (n >= 50) begin errors++; $display("FAIL sim_full_wait: got no last beat exp last beat within 50 cycles"); end
        drive_in(1'b1);
        tick();
        drive_in(1'b0);
        bus.m_ready = 1'b0;
        checks++; if (count !== CW'(D - 1)) begin errors++; $display("FAIL sim_full_count: got %0d exp %0d", count, D - 1); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sim_full_overflow: got %b exp 1", overflow); end
        // Non-full buffer: coincident write and pop leave count unchanged.
        bus.m_ready = 1'b1;
        drain(D * N + 20, to);
        for (int k = 0; k < 3; k++) begin
            bus.m_ready = 1'b0;
            drive_in(1'b1);
            tick();
        end
        drive_in(1'b0);
        bus.m_ready = 1'b1;
        n = 0;
        while (!(bus.m_valid === 1'b1 && mbeat == N - 1) && n < 50) begin tick(); n++; end
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL sim_pre_count: got %0d exp 3", count); end
        drive_in(1'b1);
        tick();
        drive_in(1'b0);
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL sim_nonfull_count: got %0d exp 3", count); end
        drain(D * N + 20, to);
        checks++; if (to) begin errors++; $display("FAIL sim_drain_timeout: got count=%0d exp 0", mcount); end
        checks++; if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL sim_beat_count: got %0d exp %0d", act_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            checks++;
            if (act_q[k].data !== exp_q[k].data || act_q[k].idx != exp_q[k].idx || act_q[k].last != exp_q[k].last) begin
                errors++;
                $display("FAIL sim_beat%0d: got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                         k, act_q[k].data, act_q[k].idx, act_q[k].last, exp_q[k].data, exp_q[k].idx, exp_q[k].last);
            end
        end
    endtask

    task automatic test_wrap();
        int  written;
        int  bubbles;
        bit  started;
        bit  wr;
        exp_q.delete(); act_q.delete();
        bus.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin drive_in(1'b1); tick(); end
        written = 5; bubbles = 0; started = 1'b0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 400 && (written < 20 || mcount != 0); c++) begin
            if (bus.m_valid === 1'b1) started = 1'b1;
            else if (started && mcount != 0) bubbles++;
            wr = (written < 20) && ((c % N) == 0) && (mcount < D);
            drive_in(wr);
            if (wr) written++;
            tick();
        end
        drive_in(1'b0);
        checks++; if (bubbles != 0) begin errors++; $display("FAIL wrap_bubbles: got %0d exp 0", bubbles); end
        checks++; if (mcount != 0) begin errors++; $display("FAIL wrap_drain_timeout: got count=%0d exp 0", mcount); end
        checks++; if (act_q.size() != 20 * N) begin errors++; $display("FAIL wrap_beat_count: got %0d exp %0d", act_q.size(), 20 * N); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            checks++;
            if (act_q[k].data !== exp_q[k].data || act_q[k].idx != exp_q[k].idx || act_q[k].last != exp_q[k].last) begin
                errors++;
                $display("FAIL wrap_beat%0d: got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                         k, act_q[k].data, act_q[k].idx, act_q[k].last, exp_q[k].data, exp_q[k].idx, exp_q[k].last);
            end
        end
    endtask

    task automatic test_reset_mid_entry();
        bit to;
        int n;
        exp_q.delete(); act_q.delete();
        bus.m_ready = 1'b0;
        for (int k = 0; k < D + 1; k++) begin drive_in(1'b1); tick(); end
        drive_in(1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rmid_pre_overflow: got %b exp 1", overflow); end
        bus.m_ready = 1'b1;
        n = 0;
        while (act_q.size() < 1 && n < 20) begin tick(); n++; end
        checks++; if (act_q.size() != 1) begin errors++; $display("FAIL rmid_first_beat: got %0d beats exp 1", act_q.size()); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rmid_m_valid: got %b exp 0", bus.m_valid); end
        checks++; if (count !== '0) begin errors++; $display("FAIL rmid_count: got %0d exp 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow: got %b exp 0", overflow); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rmid_flags: got empty=%b full=%b exp 1/0", empty, full); end
        checks++; if (bus.m_last !== 1'b0 || bus.m_inst_idx !== '0) begin errors++; $display("FAIL rmid_beat_state: got last=%b idx=%0d exp 0/0", bus.m_last, bus.m_inst_idx); end
        tick();
        checks++; if (bus.m_valid !== 1'b0 || act_q.size() != 0) begin errors++; $display("FAIL rmid_no_beat: got m_valid=%b beats=%0d exp 0/0", bus.m_valid, act_q.size()); end
        drive_in(1'b1);
        tick();
        drive_in(1'b0);
        drain(40, to);
        checks++; if (to) begin errors++; $display("FAIL rmid_drain_timeout: got count=%0d exp 0", mcount); end
        checks++; if (act_q.size() != N) begin errors++; $display("FAIL rmid_beat_count: got %0d exp %0d", act_q.size(), N); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            checks++;
            if (act_q[k].data !== exp_q[k].data || act_q[k].idx != exp_q[k].idx || act_q[k].last != exp_q[k].last) begin
                errors++;
                $display("FAIL rmid_beat%0d: got data=%h idx=%0d last=%b exp data=%h idx=%0d last=%b",
                         k, act_q[k].data, act_q[k].idx, act_q[k].last, exp_q[k].data, exp_q[k].idx, exp_q[k].last);
            end
        end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        drive_in(1'b0);
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_simultaneous();
        test_wrap();
        test_reset_mid_entry();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_result_drain_buffer

// File: doc/result_drain_buffer.md
RESULT_DRAIN_BUFFER -- requirements
Module: result_drain_buffer

Interface
REQ-001 Parameter NUMBER_OF_BUFFER_INSTANCES, default 4: result words captured per input beat, one per instance.
REQ-002 Parameter OUT_WIDTH, default OUT0_WIDTH: width of one result word.
REQ-003 Parameter DEPTH, default OUT0_DEPTH (8, power of two): number of entries held; one entry = NUMBER_OF_BUFFER_INSTANCES words.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  matmul result beat valid, driven from the matmul out_valid; no backpressure to source.
REQ-007 in_data  input  [OUT_WIDTH-1:0] x [NUMBER_OF_BUFFER_INSTANCES]  result words, instance-indexed.
REQ-008 m_valid  output  1  downstream beat valid.
REQ-009 m_ready  input  1  downstream accepts beat.
REQ-010 m_data  output  OUT_WIDTH  current beat word.
REQ-011 m_inst_idx  output  $clog2(NUMBER_OF_BUFFER_INSTANCES)  instance index of current beat.
REQ-012 m_last  output  1  high on the final beat of an entry.
REQ-013 count  output  $clog2(DEPTH)+1  entries stored, including the entry being sent.
REQ-014 full / empty  output  1 each  count==DEPTH / count==0.
REQ-015 overflow  output  1  sticky: a beat was dropped.

Function
REQ-016 Write: in_valid && !full stores all in_data words at wr_ptr and increments wr_ptr mod DEPTH; count rises the next cycle.
REQ-017 in_valid && full drops the beat, leaves pointers and storage unchanged, and sets overflow on the next edge.
REQ-018 full is evaluated on the registered count; a write arriving while full is dropped even if the same cycle completes a pop.
REQ-019 Read FSM has two states. IDLE: m_valid=0; go to SEND when count>0. SEND: m_valid=1; m_data=storage[rd_ptr][beat_idx]; m_inst_idx=beat_idx.
REQ-020 A handshake (m_valid && m_ready) increments beat_idx. When beat_idx==NUMBER_OF_BUFFER_INSTANCES-1, m_last=1; the handshake resets beat_idx to 0, increments rd_ptr mod DEPTH and decrements count.
REQ-021 After the last beat, the FSM stays in SEND if count-1>0, otherwise returns to IDLE; there is no idle bubble between back-to-back entries.
REQ-022 While m_valid=1 and m_ready=0, m_data, m_inst_idx and m_last hold stable.
REQ-023 Latency: a beat written at edge t makes m_valid high in the cycle after t+1 (IDLE→SEND at edge t+1), i.e. 2 edges from in_valid to first m_valid.
REQ-024 A simultaneous write and final-beat pop leaves count unchanged; both pointers advance.
REQ-025 Pointer wrap from DEPTH-1 to 0 requires no extra cycle.
REQ-026 overflow clears only on rst.

Reset
REQ-027 On rst=1 at a rising edge: wr_ptr=0, rd_ptr=0, beat_idx=0, count=0, FSM=IDLE, overflow=0.
REQ-028 Output values during and after reset: m_valid=0, m_last=0, m_inst_idx=0, empty=1, full=0.
REQ-029 Storage contents are not reset; m_data is don't-care while m_valid=0.
REQ-030 rst asserted mid-entry abandons the partial entry and all stored entries; no beat is emitted in the cycle after reset.

Structure
REQ-031 OUT0_WIDTH and OUT0_DEPTH shall reside in shared package out0_pkg, alongside the existing buffer0_pkg.
REQ-032 The FSM state enum (IDLE, SEND) shall be a typedef in out0_pkg.
REQ-033 Storage plus wr_ptr/rd_ptr/count shall form one sub-module, result_fifo: entry-wide write port, entry-wide asynchronous read port.
REQ-034 The serializing FSM and beat_idx counter shall reside in result_drain_buffer.

Verification
REQ-035 Basic: N=4, write one beat {A0,A1,A2,A3}, m_ready=1 → 4 beats A0..A3, m_inst_idx 0..3, m_last only on A3, empty=1 after.
REQ-036 Backpressure: m_ready toggles 1,0,0,1 → data held stable while stalled; no duplicate and no missing beats.
REQ-037 Overflow: DEPTH=8, m_ready=0, 9 writes → full=1 after the 8th; 9th dropped; overflow=1; later drain yields exactly 8 entries in order.
REQ-038 Simultaneous: full FIFO, write coincident with last-beat pop → write dropped, count=7; non-full (count=3) case → count stays 3.
REQ-039 Wrap: 20 entries streamed with m_ready=1 → output order equals input order across pointer wrap; no bubble between entries.
REQ-040 Reset mid-entry: rst pulsed after beat 1 of an entry → m_valid=0, count=0, overflow=0 next cycle; new write drains correctly.
